// File: rtl/controle_alarme_if.sv
// Keypad/sensor inputs and status outputs of the alarm controller.
// master drives the stimulus side; slave is the controller itself.
interface controle_alarme_if;
   logic       arm;
   logic [3:0] code;
   logic       code_valid;
   logic       detect;
   logic       armed;
   logic       siren;
   logic       locked;
   logic [2:0] state_out;
   logic [1:0] tries;

   modport master (
      output arm, code, code_valid, detect,
      input  armed, siren, locked, state_out, tries
   );

   modport slave (
      input  arm, code, code_valid, detect,
      output armed, siren, locked, state_out, tries
   );
endinterface

// File: rtl/controle_alarme.sv
// Alarm controller: exit/entry/siren timing, keypad disarm and wrong-code lockout.
// Moore outputs, one cycle after the causing input; no backpressure, inputs sampled every cycle.
module controle_alarme #(
   parameter int         EXIT_DELAY  = 8,
   parameter int         ENTRY_DELAY = 8,
   parameter int         SIREN_TIME  = 16,
   parameter logic [3:0] CODE        = 4'hA,
   parameter int         MAX_TRIES   = 3
) (
   input  logic               clk,
   input  logic               reset,
   controle_alarme_if.slave   bus
);

   typedef enum logic [2:0] {
      DESARMADO = 3'd0,
      SAIDA     = 3'd1,
      ARMADO    = 3'd2,
      ENTRADA   = 3'd3,
      DISPARO   = 3'd4,
      BLOQUEIO  = 3'd5
   } state_t;

   localparam logic [7:0] EXIT_LD  = 8'(EXIT_DELAY - 1);
   localparam logic [7:0] ENTRY_LD = 8'(ENTRY_DELAY - 1);
   localparam logic [7:0] SIREN_LD = 8'(SIREN_TIME - 1);
   localparam logic [2:0] MAX_T3   = 3'(MAX_TRIES);
   localparam logic [1:0] MAX_T    = 2'(MAX_TRIES);

   state_t     state_q, state_d;
   logic [7:0] timer_q, timer_d;
   logic [1:0] tries_q, tries_d;

   logic good_code, bad_code, expired, lock_now;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= DESARMADO;
         timer_q <= 8'd0;
         tries_q <= 2'd0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         tries_q <= tries_d;
      end
   end

   assign good_code = bus.code_valid && (bus.code == CODE);
   assign bad_code  = bus.code_valid && (bus.code != CODE);
   assign expired   = (timer_q == 8'd0);
   assign lock_now  = bad_code && (({1'b0, tries_q} + 3'd1) >= MAX_T3);

   // Priority inside the armed states: lockout, correct code, timer expiry, detect.
   always_comb begin
      state_d = state_q;
      timer_d = expired ? 8'd0 : timer_q - 8'd1;
      tries_d = tries_q;
      case (state_q)
         DESARMADO: begin
            if (bus.arm) begin
               state_d = SAIDA;
               timer_d = EXIT_LD;
            end
         end
         SAIDA, ARMADO, ENTRADA, DISPARO: begin
            if (lock_now) begin
               state_d = BLOQUEIO;
               tries_d = MAX_T;
               timer_d = 8'd0;
            end else if (good_code) begin
               state_d = DESARMADO;
               tries_d = 2'd0;
               timer_d = 8'd0;
            end else begin
               if (bad_code)
                  tries_d = tries_q + 2'd1;
               case (state_q)
                  SAIDA:   if (expired) state_d = ARMADO;
                  ARMADO: begin
                     if (bus.detect) begin
                        state_d = ENTRADA;
                        timer_d = ENTRY_LD;
                     end
                  end
                  ENTRADA: begin
                     if (expired) begin
                        state_d = DISPARO;
                        timer_d = SIREN_LD;
                     end
                  end
                  DISPARO: if (expired) state_d = ARMADO;
                  default: state_d = DESARMADO;
               endcase
            end
         end
         BLOQUEIO: ;
         default: begin
            state_d = DESARMADO;
            timer_d = 8'd0;
         end
      endcase
   end

   assign bus.armed     = (state_q == ARMADO) || (state_q == ENTRADA) || (state_q == DISPARO);
   assign bus.siren     = (state_q == DISPARO) || (state_q == BLOQUEIO);
   assign bus.locked    = (state_q == BLOQUEIO);
   assign bus.state_out = state_q;
   assign bus.tries     = tries_q;

endmodule

// File: doc/controle_alarme.md
CONTROLE_ALARME -- requirements
Module: controle_alarme

Interface
REQ-001 The block SHALL have parameter EXIT_DELAY, default 8: cycles spent in SAIDA before arming (range 1..255).
REQ-002 The block SHALL have parameter ENTRY_DELAY, default 8: cycles allowed in ENTRADA for a code before firing (range 1..255).
REQ-003 The block SHALL have parameter SIREN_TIME, default 16: cycles the siren sounds in DISPARO (range 1..255).
REQ-004 The block SHALL have parameter CODE, default 4'hA: the disarm code.
REQ-005 The block SHALL have parameter MAX_TRIES, default 3: wrong codes that trigger lockout (range 1..3).
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port arm, input, 1 bit: arm request, sampled each cycle.
REQ-009 The block SHALL have port code, input, 4 bits: keypad code value.
REQ-010 The block SHALL have port code_valid, input, 1 bit: code is presented this cycle.
REQ-011 The block SHALL have port detect, input, 1 bit: sequence-detector alarm output.
REQ-012 The block SHALL have port armed, output, 1 bit: system armed (ARMADO, ENTRADA or DISPARO).
REQ-013 The block SHALL have port siren, output, 1 bit: siren drive.
REQ-014 The block SHALL have port locked, output, 1 bit: keypad lockout active.
REQ-015 The block SHALL have port state_out, output, 3 bits: current state encoding.
REQ-016 The block SHALL have port tries, output, 2 bits: count of wrong codes since last disarm.

Function
REQ-017 The block SHALL have states DESARMADO=0, SAIDA=1, ARMADO=2, ENTRADA=3, DISPARO=4, BLOQUEIO=5; encodings 6 and 7 SHALL go to DESARMADO on the next edge.
REQ-018 The block SHALL be Moore: all outputs decoded from registered state/tries only, with no combinational input-to-output path.
REQ-019 The block SHALL assert siren=1 only in DISPARO and BLOQUEIO, and locked=1 only in BLOQUEIO.
REQ-020 The block SHALL use an 8-bit down-counter timer, loaded with (delay-1) on entry to SAIDA, ENTRADA and DISPARO, so that each of those states lasts exactly EXIT_DELAY, ENTRY_DELAY or SIREN_TIME cycles when uninterrupted.
REQ-021 In DESARMADO, arm=1 SHALL move to SAIDA; code_valid and detect SHALL be ignored there.
REQ-022 In SAIDA, detect SHALL be ignored and the timer expiring SHALL move to ARMADO.
REQ-023 In ARMADO, detect=1 SHALL move to ENTRADA.
REQ-024 In ENTRADA, the timer expiring SHALL move to DISPARO.
REQ-025 In DISPARO, the timer expiring SHALL move back to ARMADO (auto re-arm); detect during DISPARO SHALL NOT restart the timer.
REQ-026 In SAIDA, ARMADO, ENTRADA and DISPARO, code_valid with code==CODE SHALL move to DESARMADO and clear tries to 0.
REQ-027 In SAIDA, ARMADO, ENTRADA and DISPARO, code_valid with code!=CODE SHALL increment tries.
REQ-028 When tries would reach MAX_TRIES, the block SHALL enter BLOQUEIO instead; tries SHALL saturate at MAX_TRIES.
REQ-029 BLOQUEIO SHALL be exited only by reset; all inputs SHALL be ignored there.
REQ-030 arm SHALL be ignored outside DESARMADO.
REQ-031 For simultaneous events, the priority SHALL be: lockout > correct code > timer expiry > detect; e.g. a correct code on the same cycle as ENTRADA expiry SHALL give DESARMADO.
REQ-032 Reset asserted mid-operation SHALL abort immediately with no memory of the prior state.

Reset
REQ-033 While reset=0, the block SHALL hold state=DESARMADO, timer=0, tries=0, armed=0, siren=0, locked=0, state_out=0 asynchronously.
REQ-034 After reset releases, the first transition SHALL occur on the next rising clk edge.

Verification (EXIT_DELAY=4, ENTRY_DELAY=3, SIREN_TIME=5, CODE=4'hA, MAX_TRIES=3)
REQ-035 Arm -> state_out 1 for exactly 4 cycles, then 2 with armed=1, siren=0.
REQ-036 Armed, detect pulse, no code -> ENTRADA for 3 cycles, then siren=1 for 5 cycles, then state_out=2 again.
REQ-037 Armed, detect, then code=A valid in the 2nd ENTRADA cycle -> next cycle state_out=0, armed=0, tries=0.
REQ-038 Armed, codes 1, 2, 3 each valid -> tries 1, then 2, then state_out=5, siren=1, locked=1; a later code=A -> no change; reset=0 -> all outputs 0.
REQ-039 Correct code coincident with ENTRADA expiry -> DESARMADO, siren never asserts.
REQ-040 reset=0 asserted asynchronously mid-DISPARO (between edges) -> siren drops without a clock edge; detect ignored until armed again.
